// File: rtl/fp_ci_pkg.sv
// Shared definitions for the FP custom-instruction sequencer: opcodes,
// state encoding, counter width and the per-opcode latency lookup.
package fp_ci_pkg;

    localparam logic [7:0] OP_SUB  = 8'd0;
    localparam logic [7:0] OP_MULT = 8'd1;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_supported(input logic [7:0] op);
        return (op == OP_SUB) || (op == OP_MULT);
    endfunction

    // Latencies are module parameters, so the caller hands them in.
    function automatic logic [CNT_W-1:0] latency_for(
        input logic [7:0] op,
        input int         sub_lat,
        input int         mult_lat
    );
        logic [CNT_W-1:0] lat;
        lat = (op == OP_MULT) ? mult_lat[CNT_W-1:0] : sub_lat[CNT_W-1:0];
        return lat;
    endfunction

endpackage

// File: rtl/fp_ci_sequencer.sv
// Front end for the FP sub/mult unit: latches a request, enables the unit for
// its fixed pipeline depth, then captures the result with a one-cycle done pulse.
module fp_ci_sequencer
    import fp_ci_pkg::*;
#(
    parameter int SUB_LATENCY  = 7,
    parameter int MULT_LATENCY = 5
) (
    input  logic        clock,
    input  logic        aclr,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    input  logic [7:0]  n,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] fp_dataa,
    output logic [31:0] fp_datab,
    output logic [7:0]  fp_n,
    output logic        fp_clk_en,
    input  logic [31:0] fp_result
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] lat;

    // The FP unit only advances while we are waiting on it and the processor is not stalled.
    assign fp_clk_en = clk_en && (state == ST_WAIT);

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state    <= ST_IDLE;
            count    <= '0;
            lat      <= '0;
            done     <= 1'b0;
            result   <= '0;
            fp_dataa <= '0;
            fp_datab <= '0;
            fp_n     <= '0;
        end else if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (is_supported(n)) begin
                            fp_dataa <= dataa;
                            fp_datab <= datab;
                            fp_n     <= n;
                            lat      <= latency_for(n, SUB_LATENCY, MULT_LATENCY);
                            count    <= '0;
                            state    <= ST_WAIT;
                        end else begin
                            // Unsupported opcodes complete immediately with a zero result.
                            result <= '0;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (count == lat - 1'b1) begin
                        result <= fp_result;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fp_ci_sequencer.md
Name: fp_ci_sequencer

Overview:
- Multi-cycle custom-instruction front end for the FP sub/mult unit.
- Accepts a processor-side start/operands/opcode request and registers the operands.
- Drives the FP unit's inputs and clock enable, counts that unit's fixed pipeline latency, then captures the result and returns it with a one-cycle done pulse.
- Sits directly upstream of the FP select/compute block and feeds it; one operation in flight at a time.

Parameters:
- SUB_LATENCY, 7, FP subtract pipeline depth in enabled clock cycles (legal 1..15)
- MULT_LATENCY, 5, FP multiply pipeline depth in enabled clock cycles (legal 1..15)

Ports:
- clock  in  1  system clock; all state on rising edge
- aclr  in  1  asynchronous, active-high reset
- clk_en  in  1  processor clock enable; when low, all state frozen
- start  in  1  request strobe, sampled when clk_en=1
- dataa  in  32  operand A (IEEE-754 single)
- datab  in  32  operand B (IEEE-754 single)
- n  in  8  opcode: 0 = subtract (A-B), 1 = multiply, others unsupported
- done  out  1  one-cycle result-valid pulse
- result  out  32  captured result, held until the next accepted start
- fp_dataa  out  32  registered operand A to the FP unit
- fp_datab  out  32  registered operand B to the FP unit
- fp_n  out  8  registered opcode to the FP unit
- fp_clk_en  out  1  FP unit clock enable
- fp_result  in  32  FP unit output

Behaviour:
- Reset (aclr=1, async): state=IDLE, count=0, done=0, result=0, fp_dataa/fp_datab=0, fp_n=0, fp_clk_en=0.
- Global freeze: when clk_en=0, nothing updates (state, count, registers, done). fp_clk_en is forced 0 combinationally.
- fp_clk_en = clk_en AND (state==WAIT).
- States: IDLE, WAIT, DONE.
- IDLE, start=1 with n in {0,1}:
  - Register dataa, datab and n into fp_*.
  - Load the latency L (SUB_LATENCY for n=0, MULT_LATENCY for n=1).
  - count=0, go to WAIT.
- IDLE, start=1 with n unsupported:
  - result<=0, done<=1 next cycle, go to DONE; the FP unit is not enabled.
- WAIT: count increments each enabled cycle.
  - When count==L-1: result<=fp_result, done<=1, go to DONE.
- DONE: done<=0, go to IDLE. A start seen in DONE is ignored.
- Latency:
  - start accepted in enabled cycle 0 → done=1 in enabled cycle L+1.
  - SUB default: done at cycle 8. MULT default: done at cycle 6. Unsupported: done at cycle 1.
- Back-to-back: earliest next accepted start is the cycle after done.
- start while in WAIT or DONE: ignored. fp_* registers are not disturbed.
- Operand and opcode inputs may change freely after the start cycle.
- result updates only at capture, and to 0 on an unsupported opcode. It is stable otherwise, including while done=0.
- aclr mid-operation: immediate return to reset values. The in-flight op is discarded and no done pulse is produced.
- Counter: 4 bits, no wrap, since L≤15.
- L captured at start is used even if parameters differ per op.

Decomposition:
- Shared package fp_ci_pkg:
  - opcode constants OP_SUB=8'd0, OP_MULT=8'd1
  - state encoding (IDLE/WAIT/DONE)
  - counter width constant
- No sub-module required. Latency select is a small function in the package.
- The integrating top instantiates fp_ci_sequencer next to the FP compute block.

Test Plan:
- Reset with start held high → done=0, result=0, fp_clk_en=0 until aclr releases; no spurious op.
- start, n=0, A=0x40400000, B=0x3F800000 → done pulse exactly at cycle 8 with result=0x40000000; fp_clk_en high cycles 1..7.
- start, n=1, A=0x3FC00000, B=0x40000000 → done at cycle 6, result=0x40400000. A second start issued the cycle after done is accepted.
- start, n=8'h05 → done at cycle 1, result=0, fp_clk_en never asserted.
- Mid-WAIT extras:
  - Extra start with different operands → ignored, fp_dataa unchanged.
  - clk_en low for 3 cycles → done delayed by exactly 3 cycles, same result.
- aclr pulsed at cycle 4 of a SUB → outputs zero immediately, no done, and the next op completes normally.
